// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serial shift-register chain stages.
package piso_serializer_pkg;

   // Frame state: idle line or shifting a word out.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Width of a bit-position counter for a word of w bits.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
interface piso_serializer_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_active;
   logic             done;

   modport master (
      output load_data, load_valid,
      input  load_ready, ser_out, ser_active, done
   );

   modport slave (
      input  load_data, load_valid,
      output load_ready, ser_out, ser_active, done
   );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Mod-MODULUS up-counter with sync clear, load and terminal-count flag.
module bit_counter
   import piso_serializer_pkg::*;
#(
   parameter int unsigned MODULUS = 8,
   parameter int unsigned CW      = cnt_width(MODULUS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   assign tc = (count == CW'(MODULUS - 1));

   // Counter register: clear/reset wins over load, load wins over count.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= tc ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out loader with valid/ready input and registered serial output.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   piso_serializer_if.slave   bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bit_cnt;
   logic             last_bit;
   logic             accept;
   logic             ready;
   logic             shifting;

   assign shifting = (state == ST_SHIFT);

   // A reload on the last bit wraps the counter to 0 through load; without
   // a reload the mod-WIDTH wrap also lands on 0, ready for the next word.
   bit_counter #(
      .MODULUS (WIDTH),
      .CW      (CW)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (1'b0),
      .load     (accept),
      .load_val ('0),
      .en       (shifting),
      .count    (bit_cnt),
      .tc       (last_bit)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake and next-state decode.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      accept     = 1'b0;
      if (!rst) begin
         ready = (state == ST_IDLE) || last_bit;
      end
      accept = bus.load_valid && ready;
      case (state)
         ST_IDLE:  if (accept) state_next = ST_SHIFT;
         ST_SHIFT: if (last_bit && !accept) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Shift register; the output end drives ser_out directly, so the vacated
   // end filling with IDLE_LEVEL leaves the line idle once a word is drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= {WIDTH{IDLE_LEVEL}};
      end else if (accept) begin
         sreg <= bus.load_data;
      end else if (shifting) begin
         if (MSB_FIRST) begin
            sreg <= {sreg[WIDTH-2:0], IDLE_LEVEL};
         end else begin
            sreg <= {IDLE_LEVEL, sreg[WIDTH-1:1]};
         end
      end
   end

   assign bus.load_ready = ready;
   assign bus.ser_out    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign bus.ser_active = shifting;
   assign bus.done       = shifting && last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializer configurations plus a 4-stage SISO chain.
module tb_piso_serializer;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   nstep  = 0;

   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(W)) bus_a ();
   piso_serializer_if #(.WIDTH(W)) bus_b ();

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   // Downstream 4-stage SISO fed by the MSB-first serializer.
   logic [3:0] siso = '0;
   always @(posedge clk) siso <= {siso[2:0], bus_a.ser_out};

   // Reference: queue of bits still to appear; element 0 is the bit on the line.
   bit qa[$];
   bit qb[$];
   bit hist[$];

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s step=%0d observed=%b expected=%b", tag, nstep, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic r);
      logic rdy_a, rdy_b, exp_a;
      rst              = r;
      bus_a.load_valid = v;
      bus_a.load_data  = d;
      bus_b.load_valid = v;
      bus_b.load_data  = d;
      #1;
      rdy_a = !r && (qa.size() <= 1);
      rdy_b = !r && (qb.size() <= 1);
      check("ready_a", bus_a.load_ready, rdy_a);
      check("ready_b", bus_b.load_ready, rdy_b);
      @(posedge clk);
      nstep++;
      if (r) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() > 0) void'(qa.pop_front());
         if (qb.size() > 0) void'(qb.pop_front());
         if (v && rdy_a) for (int i = W - 1; i >= 0; i--) qa.push_back(d[i]);
         if (v && rdy_b) for (int i = 0; i < W; i++) qb.push_back(d[i]);
      end
      #1;
      exp_a = (qa.size() > 0) ? qa[0] : 1'b0;
      hist.push_back(exp_a);
      check("ser_out_a",    bus_a.ser_out,    exp_a);
      check("ser_active_a", bus_a.ser_active, qa.size() > 0);
      check("done_a",       bus_a.done,       qa.size() == 1);
      check("ser_out_b",    bus_b.ser_out,    (qb.size() > 0) ? qb[0] : 1'b1);
      check("ser_active_b", bus_b.ser_active, qb.size() > 0);
      check("done_b",       bus_b.done,       qb.size() == 1);
      if (nstep > 5) check("siso_q", siso[3], hist[hist.size() - 5]);
   endtask

   initial begin
      bus_a.load_valid = 1'b0;
      bus_a.load_data  = '0;
      bus_b.load_valid = 1'b0;
      bus_b.load_data  = '0;

      // Reset state.
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h55, 1'b1);

      // Single word, then drain to idle.
      step(1'b1, 8'hB4, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      // Valid held high: A5 then 3C back-to-back; 3C is offered mid-word.
      step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      // Reset in the middle of an all-ones word.
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      // Single set bit: LSB-first configuration leads with it.
      step(1'b1, 8'h01, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      // Word into the SISO chain.
      step(1'b1, 8'hC3, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 59) == 0);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
